// File: rtl/bitsync_pkg.sv
// Shared types and constants for the bit synchroniser blocks.
// Holds the FSM state enum, the default Gold code and the accumulator width helper.
package bitsync_pkg;

  localparam logic [14:0] GOLD15_CODE = 15'h30AE;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  function automatic int acc_width(
    input int sw,
    input int cl,
    input int os
  );
    return sw + $clog2(cl * os) + 1;
  endfunction

endpackage

// File: rtl/pn_lane_mac.sv
// Combinational +/- sum of one chip column across all lanes, with a lane mask.
// Ports: col (packed lane samples), code_bit, lane_mask in; sum (signed) out.
module pn_lane_mac #(
  parameter int LANES    = 4,
  parameter int SAMPLE_W = 2,
  parameter int ACC_W    = 9
) (
  input  logic [LANES*SAMPLE_W-1:0] col,
  input  logic                      code_bit,
  input  logic [LANES-1:0]          lane_mask,
  output logic signed [ACC_W-1:0]   sum
);

  logic signed [ACC_W-1:0] ext;

  always_comb begin
    sum = '0;
    ext = '0;
    for (int l = 0; l < LANES; l++) begin
      ext = ACC_W'($signed(col[l*SAMPLE_W +: SAMPLE_W]));
      if (lane_mask[l]) begin
        sum = code_bit ? sum + ext : sum - ext;
      end
    end
  end

endmodule

// File: rtl/pn_code_correlator.sv
// Oversampled PN-code correlator: per-lane sample history, sequential MAC per chip.
// Ports: clk, rst_n, sample_valid/ready/in, code_load/in, corr_valid/out/phase, overrun, overrun_clr.
module pn_code_correlator
  import bitsync_pkg::*;
#(
  parameter int                   CODE_LEN   = 15,
  parameter int                   OVERSAMPLE = 4,
  parameter int                   SAMPLE_W   = 2,
  parameter int                   SUM_LANES  = 1,
  parameter logic [CODE_LEN-1:0]  CODE_INIT  = GOLD15_CODE,
  parameter int                   ACC_W      = acc_width(SAMPLE_W, CODE_LEN, OVERSAMPLE),
  parameter int                   PH_W       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [SAMPLE_W-1:0]        sample_in,
  input  logic                       code_load,
  input  logic [CODE_LEN-1:0]        code_in,
  output logic                       corr_valid,
  output logic signed [ACC_W-1:0]    corr_out,
  output logic [PH_W-1:0]            corr_phase,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int KW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  state_t                  state;
  logic [SAMPLE_W-1:0]     hist [OVERSAMPLE][CODE_LEN];
  logic [PH_W-1:0]         ptr;
  logic [PH_W-1:0]         cur_lane;
  logic [KW-1:0]           chip;
  logic [CODE_LEN-1:0]     code;
  logic [CODE_LEN-1:0]     pend;
  logic                    pend_v;
  logic signed [ACC_W-1:0] acc;

  logic [OVERSAMPLE*SAMPLE_W-1:0] col;
  logic [OVERSAMPLE-1:0]          mask;
  logic signed [ACC_W-1:0]        mac_sum;
  logic                           last_chip;

  assign last_chip = (chip == KW'(CODE_LEN - 1));

  always_comb begin
    col = '0;
    for (int l = 0; l < OVERSAMPLE; l++) begin
      col[l*SAMPLE_W +: SAMPLE_W] = hist[l][chip];
    end
  end

  always_comb begin
    mask = '0;
    if (SUM_LANES != 0) begin
      mask = '1;
    end else begin
      mask[cur_lane] = 1'b1;
    end
  end

  pn_lane_mac #(
    .LANES    (OVERSAMPLE),
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .col       (col),
    .code_bit  (code[chip]),
    .lane_mask (mask),
    .sum       (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sample_ready <= 1'b1;
      corr_valid   <= 1'b0;
      corr_out     <= '0;
      corr_phase   <= '0;
      overrun      <= 1'b0;
      ptr          <= '0;
      cur_lane     <= '0;
      chip         <= '0;
      code         <= CODE_INIT;
      pend         <= '0;
      pend_v       <= 1'b0;
      acc          <= '0;
      for (int l = 0; l < OVERSAMPLE; l++) begin
        for (int k = 0; k < CODE_LEN; k++) begin
          hist[l][k] <= '0;
        end
      end
    end else begin
      corr_valid <= 1'b0;

      // a new overrun beats a simultaneous clear
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (code_load) begin
            code <= code_in;
          end
          if (sample_valid) begin
            for (int k = CODE_LEN - 1; k > 0; k--) begin
              hist[ptr][k] <= hist[ptr][k-1];
            end
            hist[ptr][0] <= sample_in;
            cur_lane     <= ptr;
            ptr          <= (ptr == PH_W'(OVERSAMPLE - 1)) ? '0 : ptr + 1'b1;
            acc          <= '0;
            chip         <= '0;
            sample_ready <= 1'b0;
            state        <= ACCUM;
          end
        end
        ACCUM: begin
          if (code_load) begin
            pend   <= code_in;
            pend_v <= 1'b1;
          end
          acc  <= acc + mac_sum;
          chip <= chip + 1'b1;
          // result registered here so corr_valid is high during DONE
          if (last_chip) begin
            corr_out   <= acc + mac_sum;
            corr_phase <= cur_lane;
            corr_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (code_load) begin
            code <= code_in;
          end else if (pend_v) begin
            code <= pend;
          end
          pend_v       <= 1'b0;
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state        <= IDLE;
          sample_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
